inst_mem_loader: RTL and testbench

- Writer side of the instruction memory that the fetch stage reads: takes a byte stream over a valid/ready handshake, packs bytes into 32-bit instruction words, and writes them to consecutive instruction-memory addresses starting at 0.
- Holds the CPU pipeline (`cpu_hold`) while a program is being loaded, so fetch never sees a half-written image.

---
 rtl/inst_mem_loader.sv | 152 +++++++++++++++
 tb/tb_inst_mem_loader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: packs a byte stream into 32-bit words and writes them to instruction memory from address 0
// Ports: clk; rst (async, active-low); start (load request, honoured in IDLE);
//   in_valid/in_data/in_ready (byte stream: length byte, then data bytes MSB first);
//   mem_we/mem_addr/mem_wdata (instruction-memory write port); busy/cpu_hold (pipeline stall);
//   done (completion pulse); word_cnt (words written this/last load).
// Option: INST_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and the chk_err output.
module inst_mem_loader #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic [ADDR_W:0]   word_cnt
`ifdef INST_LOADER_CHECKSUM_EN
  ,
  output logic              chk_err
`endif
);
  typedef enum logic [2:0] {
    IDLE, LEN, BYTES, WRITE, DONE
`ifdef INST_LOADER_CHECKSUM_EN
    , CHK
`endif
  } state_t;
  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d, word_cnt_q, word_cnt_d, word_cnt_inc;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       word_q, word_d;
  logic              in_ready_q, in_ready_d, mem_we_q, mem_we_d, busy_q, busy_d, done_q, done_d;
  logic              hs;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
  logic              chk_err_q, chk_err_d;
  localparam state_t LAST = CHK;
`else
  localparam state_t LAST = DONE;
`endif
  assign hs           = in_valid & in_ready_q;
  assign word_cnt_inc = word_cnt_q + (ADDR_W+1)'(1);
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    addr_d     = addr_q;
    word_cnt_d = word_cnt_q;
`ifdef INST_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
    chk_err_d  = chk_err_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        state_d    = LEN;
        addr_d     = '0;
        word_cnt_d = '0;
        byte_cnt_d = '0;
`ifdef INST_LOADER_CHECKSUM_EN
        csum_d     = '0;
        chk_err_d  = 1'b0;
`endif
      end
      LEN: if (hs) begin
        len_d   = (in_data == 8'd0 || 32'(in_data) > DEPTH) ? (ADDR_W+1)'(DEPTH) : (ADDR_W+1)'(in_data);
        state_d = BYTES;
      end
      BYTES: if (hs) begin
        word_d     = {word_q[23:0], in_data};
        byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
        csum_d     = csum_q ^ in_data;
`endif
        state_d    = (byte_cnt_q == 2'd3) ? WRITE : BYTES;
      end
      WRITE: begin
        addr_d     = addr_q + ADDR_W'(1);
        word_cnt_d = word_cnt_inc;
        byte_cnt_d = '0;
        state_d    = (word_cnt_inc == len_q) ? LAST : BYTES;
      end
`ifdef INST_LOADER_CHECKSUM_EN
      CHK: if (hs) begin
        chk_err_d = (in_data != csum_q);
        state_d   = DONE;
      end
`endif
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == LEN) || (state_d == BYTES)
`ifdef INST_LOADER_CHECKSUM_EN
                 || (state_d == CHK)
`endif
                 ;
    mem_we_d   = (state_d == WRITE);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      word_cnt_q <= '0;
      in_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_q     <= '0;
      chk_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      word_cnt_q <= word_cnt_d;
      in_ready_q <= in_ready_d;
      mem_we_q   <= mem_we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
      chk_err_q  <= chk_err_d;
`endif
    end
  end
  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = word_q;
  assign busy      = busy_q;
  assign cpu_hold  = busy_q;
  assign done      = done_q;
  assign word_cnt  = word_cnt_q;
`ifdef INST_LOADER_CHECKSUM_EN
  assign chk_err   = chk_err_q;
`endif
endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: scoreboard bench for inst_mem_loader
module tb_inst_mem_loader;
  localparam int ADDR_W = 6;
  logic              clk = 1'b0, rst = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [7:0]        in_data = 8'd0;
  logic              in_ready, mem_we, busy, cpu_hold, done;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   word_cnt;
`ifdef INST_LOADER_CHECKSUM_EN
  logic              chk_err;
`endif
  inst_mem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .cpu_hold(cpu_hold), .done(done), .word_cnt(word_cnt)
`ifdef INST_LOADER_CHECKSUM_EN
    , .chk_err(chk_err)
`endif
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;
  wr_t             wq[$];
  logic [ADDR_W:0] dq[$];
  int              checks = 0, failures = 0;
  logic            prev_done = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask
  task automatic bad(input string msg);
    checks++;
    failures++;
    $display("FAIL %s", msg);
  endtask
  always @(negedge clk) begin
    wr_t             e;
    logic [ADDR_W:0] n;
    if (prev_done) begin
      chk("busy_after_done", 32'(busy), 32'd0);
      chk("hold_after_done", 32'(cpu_hold), 32'd0);
    end
    prev_done = done;
    if (mem_we) begin
      if (wq.size() == 0) bad($sformatf("spurious_write addr=%0d data=%h required no write", mem_addr, mem_wdata));
      else begin
        e = wq.pop_front();
        chk("write_addr", 32'(mem_addr), 32'(e.a));
        chk("write_data", mem_wdata, e.d);
      end
    end
    if (done) begin
      if (dq.size() == 0) bad($sformatf("spurious_done word_cnt=%0d required no done", word_cnt));
      else begin
        n = dq.pop_front();
        chk("done_word_cnt", 32'(word_cnt), 32'(n));
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_hold", 32'(cpu_hold), 32'd1);
      end
    end
  end
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) bad($sformatf("send_timeout byte=%h in_ready=0 required 1", b));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (busy && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (busy) bad("idle_timeout busy=1 required 0");
    @(posedge clk);
    #1;
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_word_cnt"}, 32'(word_cnt), 32'd0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] t1[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic [7:0] t2[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    logic [7:0] b;
    repeat (2) @(posedge clk);
    #1 chk_reset_vals("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;
    wq.push_back('{6'd0, 32'h11223344});
    wq.push_back('{6'd1, 32'hAABBCCDD});
    dq.push_back(7'd2);
    pulse_start();
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("hold_after_start", 32'(cpu_hold), 32'd1);
    send_byte(8'h02);
    for (int i = 0; i < 8; i++) send_byte(t1[i]);
    wait_idle();
    chk("t1_word_cnt", 32'(word_cnt), 32'd2);
    wq.push_back('{6'd0, 32'hDEADBEEF});
    dq.push_back(7'd1);
    pulse_start();
    send_byte(8'h01);
    for (int i = 0; i < 4; i++) begin
      repeat (3) @(posedge clk);
      #1;
      chk("stall_busy", 32'(busy), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd1);
      send_byte(t2[i]);
    end
    wait_idle();
    chk("t2_word_cnt", 32'(word_cnt), 32'd1);
    for (int w = 0; w < 64; w++) begin
      b = 8'(4 * w);
      wq.push_back('{6'(w), {b, b + 8'd1, b + 8'd2, b + 8'd3}});
    end
    dq.push_back(7'd64);
    pulse_start();
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) send_byte(8'(i));
    wait_idle();
    chk("t3_word_cnt", 32'(word_cnt), 32'd64);
    wq.push_back('{6'd0, 32'h10111213});
    pulse_start();
    send_byte(8'h03);
    for (int i = 0; i < 6; i++) send_byte(8'h10 + 8'(i < 4 ? i : i + 12));
    #2 rst = 1'b0;
    #1 chk_reset_vals("midreset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("midreset_pending_writes", 32'(wq.size()), 32'd0);
    wq.push_back('{6'd0, 32'h55667788});
    dq.push_back(7'd1);
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h55);
    send_byte(8'h66);
    send_byte(8'h77);
    send_byte(8'h88);
    wait_idle();
    wq.push_back('{6'd0, 32'h01020304});
    wq.push_back('{6'd1, 32'h05060708});
    dq.push_back(7'd2);
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h01);
    send_byte(8'h02);
    pulse_start();
    chk("start_ignored_busy", 32'(busy), 32'd1);
    chk("start_ignored_ready", 32'(in_ready), 32'd1);
    for (int i = 3; i <= 8; i++) send_byte(8'(i));
    wait_idle();
    chk("t5_word_cnt", 32'(word_cnt), 32'd2);
`ifdef INST_LOADER_CHECKSUM_EN
    for (int k = 0; k < 2; k++) begin
      wq.push_back('{6'd0, 32'h01020408});
      dq.push_back(7'd1);
      pulse_start();
      chk("chk_err_cleared", 32'(chk_err), 32'd0);
      send_byte(8'h01);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h04);
      send_byte(8'h08);
      send_byte(k == 0 ? 8'h0F : 8'h0E);
      wait_idle();
      chk(k == 0 ? "chk_err_good" : "chk_err_bad", 32'(chk_err), k == 0 ? 32'd0 : 32'd1);
    end
`endif
    repeat (3) @(negedge clk);
    chk("pending_writes", 32'(wq.size()), 32'd0);
    chk("pending_done", 32'(dq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
